// File: rtl/multi_digit_led_driver.sv
// Multiplexed 7-segment driver: scans DIGITS-1..0, blanks DEAD_CYCLES per slot, frame-atomic word update.
// Latency: an/seg registered, 1 cycle behind prescaler/digit_idx. No backpressure; load is a strobe, last load wins.
// Optional build macro LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always lit).
module multi_digit_led_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 4096,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*DIGITS-1:0]       word,
  input  logic                      load,
  input  logic                      enable,
  output logic [DIGITS-1:0]         an,
  output logic [6:0]                seg,
  output logic [$clog2(DIGITS)-1:0] digit_idx,
  output logic                      frame_done
);

  localparam int IW = $clog2(DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] DEAD = PW'(DEAD_CYCLES);
  localparam logic [IW-1:0] TOP  = IW'(DIGITS - 1);

  logic [PW-1:0]            prescaler;
  logic [DIGITS-1:0][3:0]   active;
  logic [DIGITS-1:0][3:0]   pending;
  logic                     pend_vld;
  logic                     wrap;
  logic                     frame_wrap;
  logic                     dead;
  logic [3:0]               nibble;
  logic [6:0]               seg_dec;
  logic [DIGITS-1:0]        lz_blank;
  logic [DIGITS-1:0]        an_next;
  logic [6:0]               seg_next;

  assign wrap       = (prescaler == LAST);
  assign frame_wrap = wrap && (digit_idx == '0);
  assign frame_done = frame_wrap;
  assign dead       = (prescaler < DEAD);
  assign nibble     = active[digit_idx];

  always_comb begin
    seg_dec = 7'b1111111;
    case (nibble)
      4'h0: seg_dec = 7'b0000001;
      4'h1: seg_dec = 7'b1001111;
      4'h2: seg_dec = 7'b0010010;
      4'h3: seg_dec = 7'b0000110;
      4'h4: seg_dec = 7'b1001100;
      4'h5: seg_dec = 7'b0100100;
      4'h6: seg_dec = 7'b0100000;
      4'h7: seg_dec = 7'b0001111;
      4'h8: seg_dec = 7'b0000000;
      4'h9: seg_dec = 7'b0000100;
      4'hA: seg_dec = 7'b0001000;
      4'hB: seg_dec = 7'b1100000;
      4'hC: seg_dec = 7'b0110001;
      4'hD: seg_dec = 7'b1000010;
      4'hE: seg_dec = 7'b0110000;
      4'hF: seg_dec = 7'b0111000;
      default: seg_dec = 7'b1111111;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the most significant digit; a digit stays dark until a nonzero nibble is seen.
  always_comb begin
    logic nz;
    nz       = 1'b0;
    lz_blank = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      nz          = nz | (active[i] != 4'h0);
      lz_blank[i] = ~nz;
    end
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    an_next  = '1;
    seg_next = '1;
    if (!dead && enable && !lz_blank[digit_idx]) begin
      an_next[digit_idx] = 1'b0;
      seg_next           = seg_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      digit_idx <= TOP;
      active    <= '0;
      pending   <= '0;
      pend_vld  <= 1'b0;
      an        <= '1;
      seg       <= '1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      if (wrap) begin
        prescaler <= '0;
        digit_idx <= (digit_idx == '0) ? TOP : digit_idx - 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
      // Swap words only at the frame boundary so a frame never mixes two values.
      if (frame_wrap) begin
        if (load)
          active <= word;
        else if (pend_vld)
          active <= pending;
        pend_vld <= 1'b0;
      end else if (load) begin
        pending  <= word;
        pend_vld <= 1'b1;
      end
    end
  end

endmodule

// File: doc/multi_digit_led_driver.md
MULTI_DIGIT_LED_DRIVER -- requirements
Module: multi_digit_led_driver

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed 7-segment digits; legal range 2..8.
REQ-002 Parameter REFRESH_DIV, default 4096: clk cycles per digit slot; legal range 4..65536.
REQ-003 Parameter DEAD_CYCLES, default 16: blanked cycles at the start of each slot; legal range 1..REFRESH_DIV-2.
REQ-004 Port: clk  input  1  system clock; all logic on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: word  input  4*DIGITS  hex value to display; nibble i drives digit i.
REQ-007 Port: load  input  1  one-cycle strobe that captures word into the pending register.
REQ-008 Port: enable  input  1  1 = display on, 0 = all digits blanked.
REQ-009 Port: an  output  DIGITS  active-low anode per digit; an[i] selects digit i.
REQ-010 Port: seg  output  7  active-low cathodes; seg[6..0] = a,b,c,d,e,f,g.
REQ-011 Port: digit_idx  output  clog2(DIGITS)  index of the digit slot currently in progress.
REQ-012 Port: frame_done  output  1  one-cycle pulse at the end of the digit-0 slot.

Function
REQ-013 Prescaler counts 0..REFRESH_DIV-1 and wraps; on wrap, digit_idx decrements by 1, and wraps from 0 to DIGITS-1.
REQ-014 Scan order is DIGITS-1 down to 0; a frame is DIGITS slots long, i.e. DIGITS*REFRESH_DIV cycles.
REQ-015 While the prescaler < DEAD_CYCLES, an is all ones and seg is all ones (ghosting guard).
REQ-016 While the prescaler >= DEAD_CYCLES and enable=1, an[digit_idx]=0, all other anodes=1, and seg = hex decode of active nibble digit_idx.
REQ-017 Hex decode, active-low abcdefg: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-018 an and seg are registered; they reflect prescaler and digit_idx with exactly 1 cycle of latency.
REQ-019 load=1 captures word into the pending register and sets the pending flag; a later load before transfer overwrites the pending value (last load wins).
REQ-020 The active register takes the pending value only on the cycle digit_idx wraps 0 -> DIGITS-1, and only if the pending flag is set; the flag then clears. A frame never shows a mix of two words.
REQ-021 If load coincides with the wrap cycle, the word presented that cycle goes straight to active and the pending flag stays clear.
REQ-022 With enable=0, an and seg are all ones; the prescaler, digit_idx, load and transfer keep running.
REQ-023 frame_done=1 for exactly one cycle, on the wrap cycle from digit 0.

Reset
REQ-024 When reset=1 at a clock edge: prescaler=0, digit_idx=DIGITS-1, active=0, pending=0, pending flag=0, an=all ones, seg=all ones, frame_done=0.
REQ-025 Reset has priority over load and enable.
REQ-026 Reset mid-frame discards any pending word; scanning restarts at digit DIGITS-1 on the first cycle after reset deasserts.

Configuration
REQ-027 Macro LEADING_ZERO_BLANK_EN, when defined, blanks (anode held high) each active digit whose nibble is 0 and that has no nonzero nibble at a higher index; digit 0 is never blanked.
REQ-028 Without LEADING_ZERO_BLANK_EN, every digit is displayed, including leading zeros.

Verification (DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2)
REQ-029 Reset for 5 cycles -> an=1111, seg=1111111, digit_idx=3, frame_done=0 throughout.
REQ-030 Load 16'h257C, wait one frame -> slot outputs an=0111/seg=0010010, an=1011/seg=0100100, an=1101/seg=0001111, an=1110/seg=0110001, each preceded by 2 blank cycles.
REQ-031 Load 16'h1111 mid-frame while 16'h257C is displayed -> rest of the frame still shows 257C; next frame shows 1111 on all digits; frame_done pulses once every 32 cycles.
REQ-032 Load 16'hAAAA then 16'hBBBB in the same frame; then load 16'h3333 on the wrap cycle -> BBBB is never shown; 3333 is shown from the next frame.
REQ-033 Drop enable for 20 cycles -> an=1111 for that time; digit_idx sequence is unchanged; display resumes on the correct digit.
REQ-034 Load 16'h0042 -> with LEADING_ZERO_BLANK_EN, digits 3 and 2 are dark and digits 1 and 0 show 4 and 2; without the macro, the display shows 0042. Load 16'h0000 -> digit 0 shows 0 (0000001) in both builds.
